// File: rtl/aes_pkg.sv
// Shared AES types, round-count constants and GF(2^8) byte/state transforms
// used by the iterative encryption engine.
package aes_pkg;

    localparam int NB     = 4;
    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {KM_128 = 2'b00, KM_192 = 2'b01, KM_256 = 2'b10} key_mode_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as a^254 (maps 0 to 0), followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0]  t;
        logic [15:0] d;
        logic [7:0]  s;
        t = a;
        for (int unsigned i = 0; i < 6; i++) t = gmul(gmul(t, t), a);
        t = gmul(t, t);
        d = {t, t};
        s = t ^ 8'h63;
        for (int unsigned k = 1; k < 5; k++) s = s ^ d[8-k +: 8];
        return s;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [31:0]  col;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            a0  = col[31:24];
            a1  = col[23:16];
            a2  = col[15:8];
            a3  = col[7:0];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; MixColumns is bypassed on the last round.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] sub;
    logic [127:0] shf;

    always_comb begin
        sub = '0;
        for (int unsigned i = 0; i < 16; i++) sub[8*i +: 8] = sbox(state_in[8*i +: 8]);
        shf       = shift_rows(sub);
        state_out = (last ? shf : mix_columns(shf)) ^ round_key;
    end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryption engine, RPC rounds per clock.
// Define AES_KEY_LATCH_EN to register the key schedule at accept.
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int NR_MAX = 14,
    parameter int RPC    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [127:0]                in_msg,
    input  logic [1:0]                  key_mode,
    input  logic [32*NB*(NR_MAX+1)-1:0] w,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [127:0]                out_cipher,
    output logic                        busy
);

    localparam int KW = 32*NB*(NR_MAX+1);

    if (NB != aes_pkg::NB) begin : g_nb_check
        $error("aes_enc_iter: NB must be 4");
    end
    if (RPC != 1 && RPC != 2) begin : g_rpc_check
        $error("aes_enc_iter: RPC must be 1 or 2");
    end

    // Round key r is words 4r..4r+3, word 4r landing in the state's first column.
    function automatic logic [127:0] rk(input logic [KW-1:0] ks, input logic [3:0] r);
        logic [127:0] k;
        int unsigned  base;
        k = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            base = 32*(4*int'(r) + j);
            k[127-32*j -: 32] = ks[base +: 32];
        end
        return k;
    endfunction

    fsm_t                fsm_q;
    logic [3:0]          round_q;
    logic [3:0]          nr_q;
    logic [3:0]          nr_d;
    logic [127:0]        state_q;
    logic [127:0]        cipher_q;
    logic [127:0]        init_d;
    logic                valid_q;
    logic                busy_q;
    logic                up_q;
    logic                accept;
    logic                finish;
    logic [KW-1:0]       ks;
    logic [RPC:0][127:0] chain;

`ifdef AES_KEY_LATCH_EN
    logic [KW-1:0] ks_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ks_q <= '0;
        else if (accept) ks_q <= w;
    end
    assign ks = ks_q;
`else
    assign ks = w;
`endif

    always_comb begin
        case (key_mode_t'(key_mode))
            KM_128:  nr_d = 4'(NR_128);
            KM_192:  nr_d = 4'(NR_192);
            default: nr_d = 4'(NR_256);
        endcase
    end

    always_comb begin
        case (fsm_q)
            IDLE:    in_ready = up_q;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign init_d = in_msg ^ rk(w, 4'd0);
    assign finish = (round_q + 4'(RPC - 1)) == nr_q;
    assign chain[0] = state_q;

    for (genvar g = 0; g < RPC; g++) begin : g_round
        logic [3:0] rnd;
        assign rnd = round_q + 4'(g);
        aes_round u_round (
            .state_in  (chain[g]),
            .round_key (rk(ks, rnd)),
            .last      (rnd == nr_q),
            .state_out (chain[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            round_q  <= '0;
            nr_q     <= '0;
            state_q  <= '0;
            cipher_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            up_q     <= 1'b0;
        end else begin
            up_q <= 1'b1;
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= init_d;
                        nr_q    <= nr_d;
                        round_q <= 4'd1;
                        busy_q  <= 1'b1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= chain[RPC];
                    if (finish) begin
                        cipher_q <= chain[RPC];
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        fsm_q    <= DONE;
                    end else begin
                        round_q <= round_q + 4'(RPC);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (in_valid) begin
                            state_q <= init_d;
                            nr_q    <= nr_d;
                            round_q <= 4'd1;
                            busy_q  <= 1'b1;
                            fsm_q   <= RUN;
                        end else begin
                            round_q <= '0;
                            fsm_q   <= IDLE;
                        end
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign out_cipher = cipher_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter: FIPS-197 vectors plus randomised blocks
// against a table-driven byte-level AES model.
module tb_aes_enc_iter;

    localparam int NBP = 4;
    localparam int NRM = 14;
    localparam int RPC = 1;
    localparam int KW  = 32*NBP*(NRM+1);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT_MSG = 128'h00112233445566778899aabbccddeeff;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [127:0]   in_msg = '0;
    logic [1:0]     key_mode = '0;
    logic [KW-1:0]  w = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [127:0]   out_cipher;
    logic [2047:0]  sbt;
    int             n_checks = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    aes_enc_iter #(.NB(NBP), .NR_MAX(NRM), .RPC(RPC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_msg     (in_msg),
        .key_mode   (key_mode),
        .w          (w),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cipher (out_cipher),
        .busy       (busy)
    );

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbt[2047-8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] x);
        int v;
        v = int'(x) * 2;
        if (v >= 256) v = (v - 256) ^ 27;
        return 8'(v);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    function automatic logic [KW-1:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   ws [60];
        logic [KW-1:0] o;
        logic [31:0]   t;
        logic [7:0]    rc;
        o  = '0;
        rc = 8'h01;
        for (int i = 0; i < 4*(nk+7); i++) begin
            if (i < nk) begin
                ws[i] = key[255-32*i -: 32];
            end else begin
                t = ws[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = mul2(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                ws[i] = ws[i-nk] ^ t;
            end
            o[32*i +: 32] = ws[i];
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] msg, input logic [KW-1:0] wb, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = msg[127-8*i -: 8];
        for (int r = 0; r <= nr; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
                for (int i = 0; i < 16; i++) s[i] = t[(i%4) + 4*(((i/4) + (i%4)) % 4)];
                if (r < nr) begin
                    for (int c = 0; c < 4; c++)
                        for (int q = 0; q < 4; q++)
                            t[4*c+q] = mul2(s[4*c+q]) ^ mul2(s[4*c+(q+1)%4]) ^ s[4*c+(q+1)%4]
                                       ^ s[4*c+(q+2)%4] ^ s[4*c+(q+3)%4];
                    for (int i = 0; i < 16; i++) s[i] = t[i];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ wb[32*(4*r + i/4) + 8*(3 - i%4) +: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic int nk_of(input logic [1:0] km);
        return (km == 2'b00) ? 4 : (km == 2'b01) ? 6 : 8;
    endfunction

    task automatic wait_out(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic send(input logic [127:0] msg, input logic [1:0] km, input logic [KW-1:0] wb, output int lat);
        int n;
        in_msg = msg; key_mode = km; w = wb; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_msg   = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_mode = 2'($urandom_range(0, 3));
`ifdef AES_KEY_LATCH_EN
        for (int i = 0; i < KW/32; i++) w[32*i +: 32] = $urandom();
`endif
        wait_out(lat);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_cipher !== 128'h0) begin n_fail++; $display("FAIL rst_out_cipher: got %h want 0", out_cipher); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_kat();
        logic [127:0] exp_ct [3];
        int lat;
        exp_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        exp_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        exp_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int m = 0; m < 4; m++) begin
            int idx;
            int nr;
            idx = (m == 3) ? 2 : m;
            nr  = nk_of(2'(m)) + 6;
            send(KAT_MSG, 2'(m), expand(KAT_KEY, nk_of(2'(m))), lat);
            n_checks++;
            if (out_cipher !== exp_ct[idx]) begin
                n_fail++; $display("FAIL kat_cipher mode=%0d: got %h want %h", m, out_cipher, exp_ct[idx]);
            end
            n_checks++;
            if (lat != nr/RPC + 1) begin
                n_fail++; $display("FAIL kat_latency mode=%0d: got %0d want %0d", m, lat, nr/RPC + 1);
            end
            release_out();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kat_release mode=%0d: out_valid=%b want 0", m, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [KW-1:0] wb;
        logic [127:0]  ma, mb, ea, eb;
        int lat, bad;
        wb = expand({$urandom(), $urandom(), $urandom(), $urandom(), 128'h0}, 4);
        ma = {$urandom(), $urandom(), $urandom(), $urandom()};
        mb = {$urandom(), $urandom(), $urandom(), $urandom()};
        ea = ref_encrypt(ma, wb, 10);
        eb = ref_encrypt(mb, wb, 10);
        send(ma, 2'b00, wb, lat);
        for (int i = 0; i < 20; i++) begin
            bad = 0;
            if (out_valid !== 1'b1 || out_cipher !== ea || in_ready !== 1'b0) bad = 1;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b ct=%h want valid=1 ready=0 ct=%h",
                         i, out_valid, in_ready, out_cipher, ea);
            end
            @(posedge clk); #1;
        end
        in_msg = mb; key_mode = 2'b00; w = wb; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_b2b_accept: busy=%b out_valid=%b want 1/0", busy, out_valid);
        end
        wait_out(lat);
        n_checks++; if (out_cipher !== eb) begin n_fail++; $display("FAIL bp_second_cipher: got %h want %h", out_cipher, eb); end
        n_checks++; if (lat != 10/RPC + 1) begin n_fail++; $display("FAIL bp_second_latency: got %0d want %0d", lat, 10/RPC + 1); end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        int n, lat, stray;
        in_msg = KAT_MSG; key_mode = 2'b00; w = expand(KAT_KEY, 4); in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_cipher !== 128'h0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: valid=%b busy=%b ready=%b ct=%h want 0/0/0/0",
                     out_valid, busy, in_ready, out_cipher);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL midrun_stray_valid: got %0d cycles want 0", stray); end
        send(KAT_MSG, 2'b00, expand(KAT_KEY, 4), lat);
        n_checks++;
        if (out_cipher !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            n_fail++; $display("FAIL midrun_cipher: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", out_cipher);
        end
        n_checks++; if (lat != 10/RPC + 1) begin n_fail++; $display("FAIL midrun_latency: got %0d want %0d", lat, 10/RPC + 1); end
        release_out();
    endtask

    task automatic test_random();
        logic [255:0]  key;
        logic [127:0]  msg, exp_ct, held;
        logic [1:0]    km;
        logic [KW-1:0] wb;
        int lat, nr, hold;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom();
            msg    = {$urandom(), $urandom(), $urandom(), $urandom()};
            km     = 2'($urandom_range(0, 3));
            nr     = nk_of(km) + 6;
            wb     = expand(key, nk_of(km));
            exp_ct = ref_encrypt(msg, wb, nr);
            send(msg, km, wb, lat);
            n_checks++;
            if (out_cipher !== exp_ct) begin
                n_fail++; $display("FAIL rand_cipher #%0d km=%0d: got %h want %h", t, km, out_cipher, exp_ct);
            end
            n_checks++;
            if (lat != nr/RPC + 1) begin
                n_fail++; $display("FAIL rand_latency #%0d km=%0d: got %0d want %0d", t, km, lat, nr/RPC + 1);
            end
            held = out_cipher;
            hold = $urandom_range(0, 3);
            repeat (hold) begin @(posedge clk); #1; end
            n_checks++;
            if (out_valid !== 1'b1 || out_cipher !== exp_ct) begin
                n_fail++; $display("FAIL rand_hold #%0d: valid=%b ct=%h want 1 %h", t, out_valid, out_cipher, exp_ct);
            end
            release_out();
            if (held !== exp_ct) ;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sbt = SBOX_TBL;
        test_reset();
        test_kat();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
